i2s_rx: RTL

- I2S receiver, the input-direction counterpart of our PmodI2S output path. Takes SCLK, LRCLK and serial data from an external I2S source, such as the ADC side of the Pmod or a loopback of our own transmitter.
- Oversamples all pins in the system clock domain.
- Deserializes MSB-first two's-complement words and presents a left/right sample pair with a one-cycle valid strobe to the synth datapath.

---
 rtl/i2s_pkg.sv | 17 +
 rtl/i2s_sync_edge.sv | 47 ++++
 rtl/i2s_rx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SHIFT,
        PAD
    } rx_state_t;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with an optional
// registered rising-edge pulse derived from the synchronized level.
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_EN     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;
            logic rise_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    prev_q <= 1'b0;
                    rise_q <= 1'b0;
                end else begin
                    prev_q <= sync_q[SYNC_STAGES-1];
                    rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
                end
            end

            assign rise_o = rise_q;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversampled pins, MSB-first deserializer, paired L/R output.
// Optional macro I2S_RX_MONO_MIX_EN adds mono_data (floor average of the pair).
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              lrclk_in,
    input  logic              sdin_in,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
`ifdef I2S_RX_MONO_MIX_EN
    output logic [DATA_W-1:0] mono_data,
`endif
    output logic              sample_valid,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic sclk_rise;
    logic lrclk_s;
    logic sdin_s;
    logic sclk_level_unused;
    logic lr_rise_unused;
    logic sd_rise_unused;

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sclk (
        .clk_i  (clk),
        .rst_i  (rst),
        .pin_i  (sclk_in),
        .level_o(sclk_level_unused),
        .rise_o (sclk_rise)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_lrclk (
        .clk_i  (clk),
        .rst_i  (rst),
        .pin_i  (lrclk_in),
        .level_o(lrclk_s),
        .rise_o (lr_rise_unused)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sdin (
        .clk_i  (clk),
        .rst_i  (rst),
        .pin_i  (sdin_in),
        .level_o(sdin_s),
        .rise_o (sd_rise_unused)
    );

    rx_state_t         state_q, state_d;
    logic              lr_prev_q, lr_prev_d;
    logic              primed_q, primed_d;
    logic              chan_q, chan_d;
    logic              left_ok_q, left_ok_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-2:0] shift_q, shift_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] word_c;
    logic              lr_change;
    logic              start_c;
    logic              done_c;

    // The word is assembled straight from the shifter plus the live bit, so
    // the shifter only ever needs to hold DATA_W-1 earlier bits.
    assign word_c    = {shift_q, sdin_s};
    // primed_q stops the first rise after reset being read as an LR edge.
    assign lr_change = primed_q && (lrclk_s != lr_prev_q);

    always_comb begin
        state_d   = state_q;
        lr_prev_d = lr_prev_q;
        primed_d  = primed_q;
        chan_d    = chan_q;
        left_ok_d = left_ok_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        shadow_d  = shadow_q;
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        start_c   = 1'b0;
        done_c    = 1'b0;

        if (sclk_rise) begin
            lr_prev_d = lrclk_s;
            primed_d  = 1'b1;

            // DELAY means the delay slot has been consumed and the MSB is next.
            case (state_q)
                IDLE, PAD: begin
                    start_c = lr_change;
                end
                DELAY, SHIFT: begin
                    if (lr_change) begin
                        err_d     = 1'b1;
                        left_ok_d = 1'b0;
                        start_c   = 1'b1;
                    end else begin
                        shift_d = word_c[DATA_W-2:0];
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = SHIFT;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            done_c  = 1'b1;
                            state_d = PAD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (start_c) begin
                state_d = DELAY;
                cnt_d   = '0;
                shift_d = '0;
                chan_d  = lrclk_s;
            end

            if (done_c) begin
                if (chan_q == LR_LEFT) begin
                    shadow_d  = word_c;
                    left_ok_d = 1'b1;
                end else begin
                    if (left_ok_q) begin
                        left_d  = shadow_q;
                        right_d = word_c;
                        valid_d = 1'b1;
                    end
                    left_ok_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lr_prev_q <= 1'b0;
            primed_q  <= 1'b0;
            chan_q    <= LR_LEFT;
            left_ok_q <= 1'b0;
            cnt_q     <= '0;
            shift_q   <= '0;
            shadow_q  <= '0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lr_prev_q <= lr_prev_d;
            primed_q  <= primed_d;
            chan_q    <= chan_d;
            left_ok_q <= left_ok_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            shadow_q  <= shadow_d;
            left_q    <= left_d;
            right_q   <= right_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign left_data    = left_q;
    assign right_data   = right_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;

`ifdef I2S_RX_MONO_MIX_EN
    logic [DATA_W-1:0] mono_q, mono_d;
    logic [DATA_W-1:0] mix_c;

    // floor((a+b)/2) == (a>>>1) + (b>>>1) + (a[0] & b[0]); never overflows DATA_W.
    assign mix_c = {shadow_q[DATA_W-1], shadow_q[DATA_W-1:1]}
                 + {word_c[DATA_W-1], word_c[DATA_W-1:1]}
                 + {{(DATA_W-1){1'b0}}, shadow_q[0] & word_c[0]};

    assign mono_d = valid_d ? mix_c : mono_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mono_q <= '0;
        end else begin
            mono_q <= mono_d;
        end
    end

    assign mono_data = mono_q;
`endif

endmodule
